// File: rtl/brushless_ctrl.sv
// Three-phase commutation and drive sequencer: hall/brake synchronizers,
// run/brake/fault state machine, slew-limited duty and stall supervision.
module brushless_ctrl #(
  parameter int          RAMP_DIV   = 1024,
  parameter int          RAMP_STEP  = 8,
  parameter logic [10:0] MIN_DUTY   = 11'h0C0,
  parameter logic [10:0] BRAKE_DUTY = 11'h600,
  parameter int          STALL_CYC  = 2**20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic [11:0] drv_mag,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic [10:0] duty,
  output logic        fault,
  output logic        running,
  output logic [1:0]  state_dbg
);

  localparam int          RW     = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam int          SW     = $clog2(STALL_CYC + 1);
  localparam logic [10:0] STEP11 = 11'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    hall_meta;
  logic [2:0]    rot;
  logic [2:0]    rot_q;
  logic          brake_meta;
  logic          brake;
  logic          rot_valid;
  logic          mag_zero;
  logic          stall;
  logic [RW-1:0] ramp_cnt;
  logic          tick_q;
  logic [SW-1:0] stall_cnt;
  logic [10:0]   target;
  logic [10:0]   diff;
  logic [5:0]    sel_nxt;
  logic [5:0]    sel_q;

  // Brake is synchronized as active-high so a cleared synchronizer means "no brake".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_meta  <= 3'b000;
      rot        <= 3'b000;
      brake_meta <= 1'b0;
      brake      <= 1'b0;
    end else begin
      hall_meta  <= {hallGrn, hallYlw, hallBlu};
      rot        <= hall_meta;
      brake_meta <= ~brake_n;
      brake      <= brake_meta;
    end
  end

  assign rot_valid = (rot != 3'b000) && (rot != 3'b111);
  assign mag_zero  = (drv_mag == 12'd0);
  assign stall     = (stall_cnt == SW'(STALL_CYC));
  assign target    = mag_zero ? 11'd0 : (MIN_DUTY + {1'b0, drv_mag[11:2]});
  assign diff      = target - duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = 6'b00_00_00;
    if (brake) begin
      state_nxt = BRAKE;
    end else begin
      case (state)
        IDLE:    if (!mag_zero && rot_valid) state_nxt = RUN;
        RUN: begin
          if (!rot_valid || stall) state_nxt = FAULT;
          else if (mag_zero)       state_nxt = IDLE;
        end
        BRAKE:   state_nxt = IDLE;
        FAULT:   if (mag_zero) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    // Select codes are {Grn, Ylw, Blu}; 10 forward, 01 reverse, 00 coast.
    case (state)
      RUN: begin
        case (rot)
          3'b101:  sel_nxt = 6'b10_01_00;
          3'b100:  sel_nxt = 6'b10_00_01;
          3'b110:  sel_nxt = 6'b00_10_01;
          3'b010:  sel_nxt = 6'b01_10_00;
          3'b011:  sel_nxt = 6'b01_00_10;
          3'b001:  sel_nxt = 6'b00_01_10;
          default: sel_nxt = 6'b00_00_00;
        endcase
      end
      BRAKE:   sel_nxt = 6'b11_11_11;
      default: sel_nxt = 6'b00_00_00;
    endcase
  end

  // Ramp tick is registered so the first increment lands RAMP_DIV+1 clocks into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (state != RUN) begin
      ramp_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q   <= (ramp_cnt == RW'(RAMP_DIV - 1));
      ramp_cnt <= (ramp_cnt == RW'(RAMP_DIV - 1)) ? '0 : ramp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q     <= 3'b000;
      stall_cnt <= '0;
    end else begin
      rot_q <= rot;
      if (state != RUN || rot != rot_q) stall_cnt <= '0;
      else if (!stall)                  stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty    <= 11'd0;
      sel_q   <= 6'b00_00_00;
      fault   <= 1'b0;
      running <= 1'b0;
    end else begin
      sel_q   <= sel_nxt;
      fault   <= (state == FAULT);
      running <= (state == RUN);
      case (state)
        RUN: begin
          if (target < duty)              duty <= target;
          else if (tick_q && duty < target)
            duty <= duty + ((diff > STEP11) ? STEP11 : diff);
        end
        BRAKE:   duty <= BRAKE_DUTY;
        default: duty <= 11'd0;
      endcase
    end
  end

  assign selGrn    = sel_q[5:4];
  assign selYlw    = sel_q[3:2];
  assign selBlu    = sel_q[1:0];
  assign state_dbg = state;

endmodule

// File: tb/tb_brushless_ctrl.sv
// Directed bench for brushless_ctrl with fast ramp/stall parameters.
module tb_brushless_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BRAKE = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hall_v;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        fault, running;
  logic [1:0]  state_dbg;
  logic [5:0]  sel;

  int checks   = 0;
  int failures = 0;
  int spin     = 0;
  int hidx     = 0;

  logic [2:0] codes   [6];
  logic [5:0] sel_tab [8];

  assign hallGrn = hall_v[2];
  assign hallYlw = hall_v[1];
  assign hallBlu = hall_v[0];
  assign sel     = {selGrn, selYlw, selBlu};

  brushless_ctrl #(.RAMP_DIV(4), .RAMP_STEP(8), .STALL_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .drv_mag(drv_mag),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .duty(duty), .fault(fault), .running(running), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clock with the rotor advanced every 16 clocks to keep stall away.
  task automatic step_clk();
    @(negedge clk);
    spin++;
    if (spin % 16 == 0) begin
      hidx   = (hidx + 1) % 6;
      hall_v = codes[hidx];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hall_v = 3'b101; brake_n = 1'b1; drv_mag = 12'd0;
    tick(2);
    checks++; if (sel !== 6'd0)         begin failures++; $display("FAIL reset_sel got=%h exp=00", sel); end
    checks++; if (duty !== 11'd0)       begin failures++; $display("FAIL reset_duty got=%h exp=000", duty); end
    checks++; if (fault !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", fault, running); end
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    rst_n = 1'b1;
    tick(4);
    checks++; if (state_dbg !== S_IDLE || running !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0d/%b exp=0/0", state_dbg, running); end
  endtask

  task automatic test_rotation();
    hidx = 0; hall_v = codes[0];
    drv_mag = 12'h400;
    tick(1);
    checks++; if (state_dbg !== S_RUN)  begin failures++; $display("FAIL rot_enter_state got=%0d exp=%0d", state_dbg, S_RUN); end
    checks++; if (running !== 1'b0)     begin failures++; $display("FAIL rot_enter_lag got=%b exp=0", running); end
    tick(1);
    checks++; if (running !== 1'b1 || duty !== 11'd0) begin failures++; $display("FAIL rot_running got=%b/%h exp=1/000", running, duty); end
    checks++; if (sel !== sel_tab[codes[0]]) begin failures++; $display("FAIL rot_sel0 got=%h exp=%h", sel, sel_tab[codes[0]]); end
    for (int i = 1; i <= 6; i++) begin
      hall_v = codes[i % 6];
      tick(2);
      checks++; if (sel !== sel_tab[codes[i-1]]) begin failures++; $display("FAIL rot_early_%0d got=%h exp=%h", i, sel, sel_tab[codes[i-1]]); end
      tick(1);
      checks++; if (sel !== sel_tab[codes[i % 6]]) begin failures++; $display("FAIL rot_sel_%0d got=%h exp=%h", i, sel, sel_tab[codes[i % 6]]); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rot_fault_%0d got=%b exp=0", i, fault); end
      tick(17);
    end
    drv_mag = 12'd0;
    tick(2);
    checks++; if (state_dbg !== S_IDLE || running !== 1'b0 || sel !== 6'd0) begin failures++; $display("FAIL rot_exit got=%0d/%b/%h exp=0/0/00", state_dbg, running, sel); end
  endtask

  task automatic test_ramp();
    spin = 0;
    drv_mag = 12'h400;
    repeat (5) step_clk();
    checks++; if (duty !== 11'd0) begin failures++; $display("FAIL ramp_pre got=%h exp=000", duty); end
    for (int k = 1; k <= 56; k++) begin
      step_clk();
      checks++; if (duty !== 11'(8 * k)) begin failures++; $display("FAIL ramp_step_%0d got=%h exp=%h", k, duty, 11'(8 * k)); end
      repeat (3) step_clk();
    end
    repeat (4) step_clk();
    checks++; if (duty !== 11'h1C0) begin failures++; $display("FAIL ramp_settle got=%h exp=1c0", duty); end
    drv_mag = 12'h404;
    step_clk();
    checks++; if (duty !== 11'h1C1) begin failures++; $display("FAIL ramp_clamp got=%h exp=1c1", duty); end
    repeat (4) step_clk();
    checks++; if (duty !== 11'h1C1) begin failures++; $display("FAIL ramp_hold got=%h exp=1c1", duty); end
    drv_mag = 12'h100;
    step_clk();
    checks++; if (duty !== 11'h100) begin failures++; $display("FAIL ramp_drop got=%h exp=100", duty); end
    checks++; if (fault !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL ramp_flags got=%b%b exp=01", fault, running); end
    drv_mag = 12'd0;
    tick(2);
    checks++; if (state_dbg !== S_IDLE || duty !== 11'd0) begin failures++; $display("FAIL ramp_exit got=%0d/%h exp=0/000", state_dbg, duty); end
  endtask

  task automatic test_brake();
    drv_mag = 12'h400;
    tick(10);
    brake_n = 1'b0;
    tick(3);
    checks++; if (state_dbg !== S_BRAKE || running !== 1'b1) begin failures++; $display("FAIL brake_state got=%0d/%b exp=2/1", state_dbg, running); end
    tick(1);
    checks++; if (sel !== 6'b111111) begin failures++; $display("FAIL brake_sel got=%h exp=3f", sel); end
    checks++; if (duty !== 11'h600)  begin failures++; $display("FAIL brake_duty got=%h exp=600", duty); end
    checks++; if (running !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL brake_flags got=%b%b exp=00", fault, running); end
    tick(5);
    brake_n = 1'b1;
    tick(3);
    checks++; if (state_dbg !== S_IDLE || duty !== 11'h600) begin failures++; $display("FAIL brake_rel got=%0d/%h exp=0/600", state_dbg, duty); end
    tick(1);
    checks++; if (sel !== 6'd0 || duty !== 11'd0 || state_dbg !== S_RUN) begin failures++; $display("FAIL brake_idle got=%h/%h/%0d exp=00/000/1", sel, duty, state_dbg); end
    tick(1);
    checks++; if (running !== 1'b1 || duty !== 11'd0) begin failures++; $display("FAIL brake_rerun got=%b/%h exp=1/000", running, duty); end
    tick(3);
    checks++; if (duty !== 11'd0) begin failures++; $display("FAIL brake_ramp0 got=%h exp=000", duty); end
    tick(1);
    checks++; if (duty !== 11'd8) begin failures++; $display("FAIL brake_ramp1 got=%h exp=008", duty); end
    drv_mag = 12'd0;
    tick(3);
  endtask

  task automatic test_stall();
    drv_mag = 12'h400;
    tick(63);
    checks++; if (state_dbg !== S_RUN || fault !== 1'b0) begin failures++; $display("FAIL stall_early got=%0d/%b exp=1/0", state_dbg, fault); end
    tick(5);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL stall_fault got=%b exp=1", fault); end
    checks++; if (sel !== 6'd0 || duty !== 11'd0 || running !== 1'b0) begin failures++; $display("FAIL stall_outs got=%h/%h/%b exp=00/000/0", sel, duty, running); end
    tick(3);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b exp=1", fault); end
    drv_mag = 12'd0;
    tick(2);
    checks++; if (fault !== 1'b0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL stall_clear got=%b/%0d exp=0/0", fault, state_dbg); end
  endtask

  task automatic test_invalid_hall();
    drv_mag = 12'h400;
    tick(5);
    hall_v = 3'b111;
    tick(3);
    checks++; if (state_dbg !== S_FAULT) begin failures++; $display("FAIL inv_state got=%0d exp=3", state_dbg); end
    tick(1);
    checks++; if (fault !== 1'b1 || sel !== 6'd0 || duty !== 11'd0 || running !== 1'b0) begin failures++; $display("FAIL inv_outs got=%b/%h/%h/%b exp=1/00/000/0", fault, sel, duty, running); end
    tick(4);
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL inv_hold got=%b exp=1", fault); end
    drv_mag = 12'd0;
    tick(2);
    checks++; if (fault !== 1'b0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL inv_clear got=%b/%0d exp=0/0", fault, state_dbg); end
    hall_v = 3'b000;
    tick(5);
    checks++; if (state_dbg !== S_IDLE || fault !== 1'b0 || sel !== 6'd0) begin failures++; $display("FAIL inv_idle000 got=%0d/%b/%h exp=0/0/00", state_dbg, fault, sel); end
    drv_mag = 12'h400;
    tick(4);
    checks++; if (state_dbg !== S_IDLE || running !== 1'b0) begin failures++; $display("FAIL inv_noentry got=%0d/%b exp=0/0", state_dbg, running); end
    drv_mag = 12'd0;
    hall_v = codes[hidx];
    tick(3);
  endtask

  task automatic test_async_reset();
    spin = 0;
    drv_mag = 12'h400;
    repeat (82) step_clk();
    checks++; if (duty !== 11'h0A0) begin failures++; $display("FAIL arst_pre got=%h exp=0a0", duty); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (duty !== 11'd0 || sel !== 6'd0) begin failures++; $display("FAIL arst_outs got=%h/%h exp=000/00", duty, sel); end
    checks++; if (fault !== 1'b0 || running !== 1'b0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL arst_flags got=%b/%b/%0d exp=0/0/0", fault, running, state_dbg); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL arst_sync_clear got=%0d exp=0", state_dbg); end
    tick(1);
    checks++; if (state_dbg !== S_RUN) begin failures++; $display("FAIL arst_rerun got=%0d exp=1", state_dbg); end
    drv_mag = 12'd0;
    tick(2);
    checks++; if (running !== 1'b0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL arst_exit got=%b/%0d exp=0/0", running, state_dbg); end
  endtask

  initial begin
    codes[0] = 3'b101; codes[1] = 3'b100; codes[2] = 3'b110;
    codes[3] = 3'b010; codes[4] = 3'b011; codes[5] = 3'b001;
    sel_tab[3'b000] = 6'b00_00_00; sel_tab[3'b111] = 6'b00_00_00;
    sel_tab[3'b101] = 6'b10_01_00; sel_tab[3'b100] = 6'b10_00_01;
    sel_tab[3'b110] = 6'b00_10_01; sel_tab[3'b010] = 6'b01_10_00;
    sel_tab[3'b011] = 6'b01_00_10; sel_tab[3'b001] = 6'b00_01_10;
    test_reset();
    test_rotation();
    test_ramp();
    test_brake();
    test_stall();
    test_invalid_hall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
